// File: rtl/vs_slave_decoupler.sv
// Virtual Socket slave-port decoupler.
// Passes pipelined Wishbone traffic to the socket in RUN. On a decouple request it drains the
// outstanding transactions (bounded by a timeout), then isolates the socket and answers crossbar
// accesses locally. This keeps the bus from hanging while the reconfigurable module is swapped.
module vs_slave_decoupler #(
    parameter int          MAX_OUTSTANDING  = 4,
    parameter int          DRAIN_TIMEOUT    = 1024,
    parameter logic [31:0] DECOUPLED_DATA   = 32'hDEC0DEAD,
    parameter bit          ERR_ON_DECOUPLED = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        decouple_req,
    output logic        decouple_ack,
    output logic        drain_timeout,
    input  logic [17:0] xb_adr,
    input  logic [31:0] xb_dat_w,
    input  logic [3:0]  xb_sel,
    input  logic        xb_we,
    input  logic        xb_cyc,
    input  logic        xb_stb,
    output logic [31:0] xb_dat_r,
    output logic        xb_ack,
    output logic        xb_err,
    output logic        xb_stall,
    output logic [17:0] vs_adr,
    output logic [31:0] vs_dat_w,
    output logic [3:0]  vs_sel,
    output logic        vs_we,
    output logic        vs_cyc,
    output logic        vs_stb,
    input  logic [31:0] vs_dat_r,
    input  logic        vs_ack,
    input  logic        vs_err,
    input  logic        vs_stall,
    input  logic        vs_irq_in,
    output logic        irq_out
);

    localparam int             TW       = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]     MAX_OUT  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DECOUPLED
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    out_cnt, out_cnt_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          tmo_flag, tmo_flag_nxt;
    logic          loc_vld_p1, loc_vld_nxt;

    logic          full;
    logic          accept;
    logic          accept_fwd;
    logic          resp;

    // Request fields always follow the crossbar; cyc/stb qualify them on the socket side.
    assign vs_adr   = xb_adr;
    assign vs_dat_w = xb_dat_w;
    assign vs_sel   = xb_sel;
    assign vs_we    = xb_we;

    assign full          = (out_cnt == MAX_OUT);
    assign decouple_ack  = (state == ST_DECOUPLED);
    assign drain_timeout = tmo_flag;

    // Per-state routing of handshakes, responses and interrupt between crossbar and socket.
    always_comb begin
        vs_cyc   = 1'b0;
        vs_stb   = 1'b0;
        xb_stall = 1'b1;
        xb_ack   = 1'b0;
        xb_err   = 1'b0;
        xb_dat_r = vs_dat_r;
        irq_out  = 1'b0;
        case (state)
            ST_RUN: begin
                vs_cyc   = xb_cyc;
                vs_stb   = xb_stb & ~full;
                xb_stall = vs_stall | full;
                xb_ack   = vs_ack;
                xb_err   = vs_err;
                irq_out  = vs_irq_in;
            end
            ST_DRAIN: begin
                vs_cyc   = xb_cyc & (out_cnt != 4'd0);
                xb_ack   = vs_ack;
                xb_err   = vs_err;
            end
            ST_DECOUPLED: begin
                // The reconnect cycle stalls so no new access is accepted that would need a local
                // answer after the socket is already back in RUN.
                xb_stall = ~decouple_req;
                xb_dat_r = DECOUPLED_DATA;
                xb_ack   = loc_vld_p1 & xb_cyc & ~ERR_ON_DECOUPLED;
                xb_err   = loc_vld_p1 & xb_cyc &  ERR_ON_DECOUPLED;
            end
            default: begin
                xb_stall = 1'b1;
            end
        endcase
    end

    assign accept     = xb_cyc & xb_stb & ~xb_stall;
    assign accept_fwd = accept & (state == ST_RUN);
    assign resp       = (vs_ack | vs_err) & (state != ST_DECOUPLED);

    // Next-state logic: outstanding tracking, drain timer, sticky timeout flag, local response.
    always_comb begin
        state_nxt    = state;
        out_cnt_nxt  = out_cnt;
        timer_nxt    = timer;
        tmo_flag_nxt = tmo_flag;
        loc_vld_nxt  = 1'b0;

        if (!xb_cyc) begin
            out_cnt_nxt = 4'd0;
        end else if (accept_fwd && !resp) begin
            out_cnt_nxt = out_cnt + 4'd1;
        end else if (!accept_fwd && resp && (out_cnt != 4'd0)) begin
            out_cnt_nxt = out_cnt - 4'd1;
        end

        case (state)
            ST_RUN: begin
                if (decouple_req) begin
                    state_nxt    = ST_DRAIN;
                    timer_nxt    = '0;
                    tmo_flag_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                timer_nxt = timer + TW'(1);
                if (out_cnt_nxt == 4'd0) begin
                    state_nxt = ST_DECOUPLED;
                end else if (timer == TMO_LAST) begin
                    state_nxt    = ST_DECOUPLED;
                    tmo_flag_nxt = 1'b1;
                    out_cnt_nxt  = 4'd0;
                end
            end
            ST_DECOUPLED: begin
                loc_vld_nxt = accept;
                if (!decouple_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // State and counter registers; reset abandons any pending local response.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            out_cnt    <= 4'd0;
            timer      <= '0;
            tmo_flag   <= 1'b0;
            loc_vld_p1 <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_cnt    <= out_cnt_nxt;
            timer      <= timer_nxt;
            tmo_flag   <= tmo_flag_nxt;
            loc_vld_p1 <= loc_vld_nxt;
        end
    end

endmodule

// File: tb/tb_vs_slave_decoupler.sv
// Directed bench for vs_slave_decoupler with a response scoreboard.
module tb_vs_slave_decoupler;

    logic        sys_clk;
    logic        rst_n;
    logic        decouple_req;
    logic        decouple_ack;
    logic        drain_timeout;
    logic [17:0] xb_adr;
    logic [31:0] xb_dat_w;
    logic [3:0]  xb_sel;
    logic        xb_we;
    logic        xb_cyc;
    logic        xb_stb;
    logic [31:0] xb_dat_r;
    logic        xb_ack;
    logic        xb_err;
    logic        xb_stall;
    logic [17:0] vs_adr;
    logic [31:0] vs_dat_w;
    logic [3:0]  vs_sel;
    logic        vs_we;
    logic        vs_cyc;
    logic        vs_stb;
    logic [31:0] vs_dat_r;
    logic        vs_ack;
    logic        vs_err;
    logic        vs_stall;
    logic        vs_irq_in;
    logic        irq_out;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    vs_slave_decoupler #(
        .MAX_OUTSTANDING (4),
        .DRAIN_TIMEOUT   (16),
        .DECOUPLED_DATA  (32'hDEC0DEAD),
        .ERR_ON_DECOUPLED(1'b1)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .decouple_req (decouple_req),
        .decouple_ack (decouple_ack),
        .drain_timeout(drain_timeout),
        .xb_adr       (xb_adr),
        .xb_dat_w     (xb_dat_w),
        .xb_sel       (xb_sel),
        .xb_we        (xb_we),
        .xb_cyc       (xb_cyc),
        .xb_stb       (xb_stb),
        .xb_dat_r     (xb_dat_r),
        .xb_ack       (xb_ack),
        .xb_err       (xb_err),
        .xb_stall     (xb_stall),
        .vs_adr       (vs_adr),
        .vs_dat_w     (vs_dat_w),
        .vs_sel       (vs_sel),
        .vs_we        (vs_we),
        .vs_cyc       (vs_cyc),
        .vs_stb       (vs_stb),
        .vs_dat_r     (vs_dat_r),
        .vs_ack       (vs_ack),
        .vs_err       (vs_err),
        .vs_stall     (vs_stall),
        .vs_irq_in    (vs_irq_in),
        .irq_out      (irq_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then retire any crossbar response against the scoreboard.
    task automatic settle();
        rsp_t e;
        #2;
        if (xb_ack === 1'b1 || xb_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", {30'd0, xb_ack, xb_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rsp_err", xb_err, e.is_err);
                chk("sb_rsp_ack", xb_ack, !e.is_err);
                chk("sb_rsp_data", xb_dat_r, e.data);
            end
        end
    endtask

    task automatic clk();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [31:0] data);
        rsp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    initial begin
        rst_n        = 1'b0;
        decouple_req = 1'b0;
        xb_adr       = 18'h0;
        xb_dat_w     = 32'h0;
        xb_sel       = 4'hF;
        xb_we        = 1'b0;
        xb_cyc       = 1'b0;
        xb_stb       = 1'b0;
        vs_dat_r     = 32'h0;
        vs_ack       = 1'b0;
        vs_err       = 1'b0;
        vs_stall     = 1'b0;
        vs_irq_in    = 1'b0;

        // Reset values
        settle();
        chk("rst_decouple_ack", decouple_ack, 1'b0);
        chk("rst_drain_timeout", drain_timeout, 1'b0);
        chk("rst_xb_ack", xb_ack, 1'b0);
        chk("rst_xb_err", xb_err, 1'b0);
        clk();
        clk();
        rst_n = 1'b1;

        // RUN read, socket acks two cycles after the accept
        xb_cyc = 1'b1; xb_stb = 1'b1; xb_adr = 18'h0_1234;
        settle();
        chk("run_vs_stb", vs_stb, 1'b1);
        chk("run_xb_stall", xb_stall, 1'b0);
        chk("run_vs_adr", {14'd0, vs_adr}, {14'd0, 18'h0_1234});
        push(1'b0, 32'h0000510b);
        clk();
        xb_stb = 1'b0;
        settle();
        clk();
        vs_ack = 1'b1; vs_dat_r = 32'h0000510b;
        settle();
        chk("run_xb_ack", xb_ack, 1'b1);
        clk();
        vs_ack = 1'b0; xb_cyc = 1'b0;
        settle();
        clk();
        chk("run_sb_empty", sb_q.size(), 0);

        // Full: four accepts without acks stall the crossbar
        xb_cyc = 1'b1; xb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("full_accept_stall", xb_stall, 1'b0);
            push(1'b0, 32'h100 + 32'(i));
            clk();
        end
        vs_ack = 1'b1; vs_dat_r = 32'h100;
        settle();
        chk("full_xb_stall", xb_stall, 1'b1);
        chk("full_vs_stb", vs_stb, 1'b0);
        clk();
        vs_ack = 1'b0; xb_stb = 1'b0;
        settle();
        chk("full_stall_drop", xb_stall, 1'b0);
        clk();
        for (int i = 1; i < 4; i++) begin
            vs_ack = 1'b1; vs_dat_r = 32'h100 + 32'(i);
            settle();
            clk();
        end
        vs_ack = 1'b0;
        settle();
        chk("full_sb_empty", sb_q.size(), 0);

        // Drain with two outstanding transactions
        xb_stb = 1'b1;
        settle(); push(1'b0, 32'hA1); clk();
        settle(); push(1'b0, 32'hA2); clk();
        xb_stb = 1'b0; decouple_req = 1'b1;
        settle();
        clk();
        xb_stb = 1'b1; vs_ack = 1'b1; vs_dat_r = 32'hA1;
        settle();
        chk("drain_xb_stall", xb_stall, 1'b1);
        chk("drain_vs_stb", vs_stb, 1'b0);
        chk("drain_vs_cyc", vs_cyc, 1'b1);
        chk("drain_ack_low", decouple_ack, 1'b0);
        clk();
        xb_stb = 1'b0; vs_dat_r = 32'hA2;
        settle();
        chk("drain_ack_low2", decouple_ack, 1'b0);
        clk();
        vs_ack = 1'b0;
        settle();
        chk("drain_decouple_ack", decouple_ack, 1'b1);
        chk("drain_no_timeout", drain_timeout, 1'b0);
        chk("drain_vs_cyc_off", vs_cyc, 1'b0);
        chk("drain_sb_empty", sb_q.size(), 0);
        clk();

        // Decoupled: three back-to-back reads answered locally; socket ack and irq are ignored
        vs_irq_in = 1'b1; xb_stb = 1'b1; vs_ack = 1'b1;
        settle();
        chk("dec_xb_stall", xb_stall, 1'b0);
        chk("dec_vs_cyc", vs_cyc, 1'b0);
        chk("dec_irq_out", irq_out, 1'b0);
        chk("dec_no_early_rsp", {30'd0, xb_ack, xb_err}, 32'd0);
        push(1'b1, 32'hDEC0DEAD);
        clk();
        vs_ack = 1'b0;
        settle(); push(1'b1, 32'hDEC0DEAD); clk();
        settle(); push(1'b1, 32'hDEC0DEAD); clk();
        xb_stb = 1'b0;
        settle();
        chk("dec_last_err", xb_err, 1'b1);
        clk();
        settle();
        chk("dec_sb_empty", sb_q.size(), 0);

        // Reconnect while a local response is pending
        xb_stb = 1'b1;
        settle(); push(1'b1, 32'hDEC0DEAD); clk();
        xb_stb = 1'b0; decouple_req = 1'b0;
        settle();
        chk("recon_xb_stall", xb_stall, 1'b1);
        chk("recon_ack_held", decouple_ack, 1'b1);
        clk();
        settle();
        chk("recon_run", decouple_ack, 1'b0);
        chk("recon_irq_out", irq_out, 1'b1);
        chk("recon_vs_cyc", vs_cyc, 1'b1);
        chk("recon_sb_empty", sb_q.size(), 0);
        vs_irq_in = 1'b0;
        clk();

        // Timeout: one transaction that is never acked
        xb_stb = 1'b1;
        settle(); clk();
        xb_stb = 1'b0; decouple_req = 1'b1;
        settle(); clk();
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("tmo_wait_ack_low", decouple_ack, 1'b0);
            clk();
        end
        vs_ack = 1'b1; vs_dat_r = 32'hBAD;
        settle();
        chk("tmo_decouple_ack", decouple_ack, 1'b1);
        chk("tmo_flag", drain_timeout, 1'b1);
        chk("tmo_late_ack_dropped", xb_ack, 1'b0);
        clk();
        vs_ack = 1'b0;

        // Reset while a local response is pending
        xb_stb = 1'b1;
        settle(); clk();
        xb_stb = 1'b0; decouple_req = 1'b0; rst_n = 1'b0;
        settle();
        chk("rstrsp_xb_err", xb_err, 1'b0);
        chk("rstrsp_decouple_ack", decouple_ack, 1'b0);
        chk("rstrsp_drain_timeout", drain_timeout, 1'b0);
        clk();
        rst_n = 1'b1;
        settle(); clk();

        // Reset in the middle of DRAIN
        xb_stb = 1'b1;
        settle(); clk();
        xb_stb = 1'b0; decouple_req = 1'b1;
        settle(); clk();
        settle();
        chk("rstdrn_in_drain", xb_stall, 1'b1);
        rst_n = 1'b0; decouple_req = 1'b0; xb_stb = 1'b1;
        settle();
        chk("rstdrn_xb_stall", xb_stall, 1'b0);
        chk("rstdrn_vs_stb", vs_stb, 1'b1);
        chk("rstdrn_decouple_ack", decouple_ack, 1'b0);
        chk("rstdrn_drain_timeout", drain_timeout, 1'b0);
        clk();
        xb_stb = 1'b0; xb_cyc = 1'b0;
        rst_n = 1'b1;
        settle(); clk();

        chk("final_sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
